module_display_scan: RTL and testbench

Parametrised multiplexed 7-segment display driver with a built-in refresh prescaler, clocked from the 10 MHz system clock. It scans `N_DIGITS` common-anode digits in turn, one digit per refresh period. It decodes each digit's hex nibble to active-low cathodes and supports per-digit blanking, per-digit decimal points and a global enable. It sits between the datapath registers and the board's anode/cathode pins, and replaces single-rate cathode-tick generators.

---
 rtl/pkg_display.sv | 23 ++
 rtl/module_tick_gen.sv | 37 +++
 rtl/module_display_scan.sv | 88 ++++++++
 tb/tb_module_display_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_display.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   seg_t      : active-low segment vector, bit 0 = a ... bit 6 = g
//   SEG_OFF    : all segments dark
//   SEG_LUT    : hex nibble to active-low segment pattern
//   seg_decode : table lookup helper
package pkg_display;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/module_tick_gen.sv
// Refresh prescaler: counts 0..COUNT-1 while enabled and pulses tick for one
// cycle each time the count wraps. The count freezes while en is low.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   en     : count enable
//   tick   : registered one-cycle pulse, high after each wrap edge
//   wrap_c : combinational "this edge wraps", lets the parent advance state
//            on the same edge that raises tick
module module_tick_gen #(
    parameter int unsigned COUNT = 10_000,
    parameter int unsigned BITS  = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick,
    output logic wrap_c
);

    logic [BITS-1:0] r_count;

    assign wrap_c = en && (r_count == BITS'(COUNT - 1));

    // Counter and tick pulse; a disabled cycle holds the count and drops tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap_c;
            if (en) begin
                r_count <= wrap_c ? '0 : r_count + BITS'(1);
            end
        end
    end

endmodule

// File: rtl/module_display_scan.sv
// Multiplexed common-anode 7-segment display driver. Scans N_DIGITS digits,
// one per COUNT_REFRESH-cycle slot, with hex decode, per-digit blanking,
// per-digit decimal points and a global enable.
//   clk_10Mhz_i : system clock
//   reset_i     : asynchronous active-high reset
//   enable_i    : scan enable; low darkens the display and freezes the scan
//   data_i      : packed hex digits, digit k at [4k+3:4k]
//   blank_i     : per-digit blank
//   dp_i        : per-digit decimal point (active high)
//   anodo_o     : active-low one-hot digit select
//   catodo_o    : active-low segments a..g
//   dp_o        : active-low decimal point
//   tick_o      : one-cycle pulse on each slot advance
//   digit_idx_o : current slot index
module module_display_scan
    import pkg_display::*;
#(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned COUNT_REFRESH = 10_000,
    parameter int unsigned BITS_REFRESH  = 14,
    localparam int unsigned IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                    clk_10Mhz_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [4*N_DIGITS-1:0]   data_i,
    input  logic [N_DIGITS-1:0]     blank_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    output logic [N_DIGITS-1:0]     anodo_o,
    output logic [6:0]              catodo_o,
    output logic                    dp_o,
    output logic                    tick_o,
    output logic [IDX_W-1:0]        digit_idx_o
);

    logic             w_wrap;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic             w_dp;
    logic [N_DIGITS-1:0] w_anodo;

    module_tick_gen #(
        .COUNT (COUNT_REFRESH),
        .BITS  (BITS_REFRESH)
    ) u_tick_gen (
        .clk    (clk_10Mhz_i),
        .reset  (reset_i),
        .en     (enable_i),
        .tick   (tick_o),
        .wrap_c (w_wrap)
    );

    // Slot index advances on the wrap edge, so it changes together with tick_o.
    always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
        if (reset_i) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign digit_idx_o = r_idx;

    // Select the current digit's fields from the packed inputs.
    assign w_nibble = 4'(data_i >> {r_idx, 2'b00});
    assign w_blank  = 1'(blank_i >> r_idx);
    assign w_dp     = 1'(dp_i >> r_idx);
    assign w_anodo  = ~(N_DIGITS'(1) << r_idx);

    // Display register: reloaded every cycle, so it trails the index by one edge.
    always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
        if (reset_i) begin
            anodo_o  <= '1;
            catodo_o <= SEG_OFF;
            dp_o     <= 1'b1;
        end else if (!enable_i || w_blank) begin
            anodo_o  <= '1;
            catodo_o <= SEG_OFF;
            dp_o     <= 1'b1;
        end else begin
            anodo_o  <= w_anodo;
            catodo_o <= seg_decode(w_nibble);
            dp_o     <= ~w_dp;
        end
    end

endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan (N_DIGITS=4, COUNT_REFRESH=4).
// A reference model, driven by the count of enabled edges since reset,
// pushes the expected post-edge outputs; a monitor pops and compares.
module tb_module_display_scan;

    localparam int N = 4;
    localparam int C = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       tick;
        logic [1:0] idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  anodo;
    logic [6:0]  catodo;
    logic        dp_out;
    logic        tick;
    logic [1:0]  idx;

    int   vectors;
    int   miscompares;
    int   n_en;          // enabled edges since last reset
    exp_t q[$];

    logic [6:0] seg_ref [16];

    module_display_scan #(
        .N_DIGITS      (N),
        .COUNT_REFRESH (C),
        .BITS_REFRESH  (2)
    ) dut (
        .clk_10Mhz_i (clk),
        .reset_i     (rst),
        .enable_i    (en),
        .data_i      (data),
        .blank_i     (blank),
        .dp_i        (dp),
        .anodo_o     (anodo),
        .catodo_o    (catodo),
        .dp_o        (dp_out),
        .tick_o      (tick),
        .digit_idx_o (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: the slot on display is floor(n/C) mod N, where n counts
    // enabled edges; the display shows the slot in effect before the edge.
    always @(posedge clk) begin
        if (!rst) begin
            exp_t       e;
            int         slot;
            logic [15:0] sh;
            if (en) begin
                slot = (n_en / C) % N;
                sh   = data >> (4 * slot);
                if (blank[slot]) begin
                    e.an  = 4'hF;
                    e.cat = 7'h7F;
                    e.dp  = 1'b1;
                end else begin
                    e.an  = 4'hF ^ (4'(1) << slot);
                    e.cat = seg_ref[sh[3:0]];
                    e.dp  = ~dp[slot];
                end
                n_en   = n_en + 1;
                e.tick = ((n_en % C) == 0);
            end else begin
                e.an   = 4'hF;
                e.cat  = 7'h7F;
                e.dp   = 1'b1;
                e.tick = 1'b0;
            end
            e.idx = 2'((n_en / C) % N);
            q.push_back(e);
        end
    end

    // Monitor: compare every expected entry just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            check("anodo",  int'(anodo),  int'(e.an));
            check("catodo", int'(catodo), int'(e.cat));
            check("dp_o",   int'(dp_out), int'(e.dp));
            check("tick",   int'(tick),   int'(e.tick));
            check("idx",    int'(idx),    int'(e.idx));
        end
    end

    // Assert reset between edges and check outputs without waiting for a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        check("rst_anodo",  int'(anodo),  'hF);
        check("rst_catodo", int'(catodo), 'h7F);
        check("rst_dp",     int'(dp_out), 1);
        check("rst_tick",   int'(tick),   0);
        check("rst_idx",    int'(idx),    0);
        q.delete();
        n_en = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while ((n_en % (N * C)) != ph && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            miscompares++;
            $display("FAIL wait_phase: timeout, expected phase %0d", ph);
        end
    endtask

    initial begin
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vectors     = 0;
        miscompares = 0;
        n_en        = 0;
        rst   = 1'b1;
        en    = 1'b0;
        data  = 16'h1234;
        blank = 4'h0;
        dp    = 4'h0;
        #2;
        vectors++;
        check("init_anodo",  int'(anodo),  'hF);
        check("init_catodo", int'(catodo), 'h7F);
        check("init_idx",    int'(idx),    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic scan
        en = 1'b1;
        run(20);
        // Mid-scan asynchronous reset
        run(2);
        async_reset();

        // Hex digits and decimal point on digit 0
        data = 16'hF0AE;
        dp   = 4'b0001;
        run(20);

        // Enable gap after one cycle of slot 2
        dp   = 4'b0000;
        data = 16'h1234;
        wait_phase(9);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(12);

        // Blanking of digit 2
        blank = 4'b0100;
        run(20);
        blank = 4'b0000;

        // Mid-slot data change during slot 0
        wait_phase(1);
        data = 16'h1238;
        run(8);

        async_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) blank = 4'($urandom);
            if ($urandom_range(0, 5) == 0) dp = 4'($urandom);
            @(negedge clk);
            if (i == 200) begin
                async_reset();
            end
        end
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
